// File: rtl/rst_seq_pkg.sv
// Shared types and default timing constants for the reset release sequencer.
package rst_seq_pkg;

  localparam int unsigned StateW        = 2;
  localparam int unsigned DefStageDly   = 16;
  localparam int unsigned DefAckTimeout = 255;

  typedef enum logic [StateW-1:0] {
    StHold,
    StWaitAck,
    StDone
  } state_e;

endpackage

// File: rtl/rst_seq_if.sv
// Sequencer-facing signals: software re-reset request, per-stage acks, stage resets and status.
interface rst_seq_if #(
  parameter int unsigned NUM_STAGES = 3
);

  logic                  sw_rst_req;
  logic [NUM_STAGES-1:0] stage_ack_i;
  logic [NUM_STAGES-1:0] stage_rst_o;
  logic                  all_ready;
  logic                  busy;
  logic                  timeout_err;

  modport master (
    input  sw_rst_req,
    input  stage_ack_i,
    output stage_rst_o,
    output all_ready,
    output busy,
    output timeout_err
  );

  modport slave (
    output sw_rst_req,
    output stage_ack_i,
    input  stage_rst_o,
    input  all_ready,
    input  busy,
    input  timeout_err
  );

endinterface

// File: rtl/rst_seq_cnt.sv
// Clear/enable up-counter with a terminal-value match flag; clear wins over enable.
module rst_seq_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] match_val_i,
  output logic             match_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign match_o = (cnt_q == match_val_i);

endmodule

// File: rtl/rst_seq.sv
// Reset release sequencer: releases stage resets in index order, each after a settle delay and
// gated by the previous stage's ack. Optional ack timeout enabled by RST_SEQ_TIMEOUT_EN.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned STAGE_DLY   = DefStageDly,
  parameter int unsigned ACK_TIMEOUT = DefAckTimeout,
  parameter int unsigned CNT_W       = 8
) (
  input logic       clk,
  input logic       rst,
  rst_seq_if.master seq_if
);

  localparam int unsigned     IdxW    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_STAGES - 1);

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  all_ready_q, all_ready_d;
  logic                  busy_q, busy_d;
  logic                  tmo_err_q, tmo_err_d;
  logic                  cnt_clr, cnt_en, cnt_match, ack, tmo;
  logic [CNT_W-1:0]      cnt_match_val;

  // One counter serves both the settle delay (HOLD) and the ack timeout (WAIT_ACK).
  assign cnt_match_val = (state_q == StWaitAck) ? CNT_W'(ACK_TIMEOUT - 1) : CNT_W'(STAGE_DLY - 1);
  assign ack           = seq_if.stage_ack_i[idx_q];

`ifdef RST_SEQ_TIMEOUT_EN
  assign tmo = (state_q == StWaitAck) && cnt_match && !ack;
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stage_rst_d = stage_rst_q;
    all_ready_d = all_ready_q;
    busy_d      = busy_q;
    tmo_err_d   = tmo_err_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      StHold: begin
        cnt_en = 1'b1;
        if (cnt_match) begin
          stage_rst_d[idx_q] = 1'b0;
          cnt_clr            = 1'b1;
          state_d            = StWaitAck;
        end
      end
      StWaitAck: begin
`ifdef RST_SEQ_TIMEOUT_EN
        cnt_en = 1'b1;
`endif
        if (ack || tmo) begin
          cnt_clr = 1'b1;
          if (tmo) begin
            tmo_err_d = 1'b1;
          end
          if (idx_q == LastIdx) begin
            state_d     = StDone;
            all_ready_d = 1'b1;
            busy_d      = 1'b0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StHold;
          end
        end
      end
      StDone: begin
      end
      default: state_d = StHold;
    endcase

    // Software re-reset restarts the whole sequence and also drops the sticky error.
    if (seq_if.sw_rst_req) begin
      state_d     = StHold;
      idx_d       = '0;
      stage_rst_d = '1;
      all_ready_d = 1'b0;
      busy_d      = 1'b1;
      tmo_err_d   = 1'b0;
      cnt_clr     = 1'b1;
    end
    if (rst) begin
      cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHold;
      idx_q       <= '0;
      stage_rst_q <= '1;
      all_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stage_rst_q <= stage_rst_d;
      all_ready_q <= all_ready_d;
      busy_q      <= busy_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  rst_seq_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i      (clk),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .match_val_i(cnt_match_val),
    .match_o    (cnt_match)
  );

  assign seq_if.stage_rst_o = stage_rst_q;
  assign seq_if.all_ready   = all_ready_q;
  assign seq_if.busy        = busy_q;
  assign seq_if.timeout_err = tmo_err_q;

endmodule
